// File: rtl/alu4_pkg.sv
// Shared opcode encodings and FSM state type for the 4-bit ALU command block.
// Latency: none (declarations only).
// Backpressure: n/a.
package alu4_pkg;

    localparam logic [3:0] OP_OR_A  = 4'd0;   // reduction OR of a
    localparam logic [3:0] OP_XOR_A = 4'd1;   // reduction XOR of a
    localparam logic [3:0] OP_AND_A = 4'd2;   // reduction AND of a
    localparam logic [3:0] OP_LNOT_A = 4'd3;  // logical not of a
    localparam logic [3:0] OP_INV_A = 4'd4;   // bitwise invert of a
    localparam logic [3:0] OP_LNOT_B = 4'd5;  // logical not of b
    localparam logic [3:0] OP_INV_B = 4'd6;   // bitwise invert of b
    localparam logic [3:0] OP_AND_B = 4'd7;   // reduction AND of b
    localparam logic [3:0] OP_AND   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_XOR   = 4'd10;
    localparam logic [3:0] OP_GT    = 4'd11;
    localparam logic [3:0] OP_LT    = 4'd12;
    localparam logic [3:0] OP_EQ    = 4'd13;
    localparam logic [3:0] OP_ADD   = 4'd14;
    localparam logic [3:0] OP_SUB   = 4'd15;

    // IDLE: nothing held; EXEC: response freshly loaded; HOLD: response stalled
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic [3:0] zext1(input logic bit_in);
        return {3'b000, bit_in};
    endfunction

endpackage

// File: rtl/alu4_core.sv
// Purely combinational 4-bit ALU: x is the low nibble, y the high nibble.
// Latency: 0 cycles.
// Backpressure: none, output follows inputs.
module alu4_core
    import alu4_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] op,
    output logic [3:0] x,
    output logic [3:0] y
);

    logic [7:0] wide;

    // Opcode decode; single-bit results are zero-extended, y only used by add/sub
    always_comb begin
        x    = 4'h0;
        y    = 4'h0;
        wide = 8'h00;
        case (op)
            OP_OR_A:   x = zext1(|a);
            OP_XOR_A:  x = zext1(^a);
            OP_AND_A:  x = zext1(&a);
            OP_LNOT_A: x = zext1(!a);
            OP_INV_A:  x = ~a;
            OP_LNOT_B: x = zext1(!b);
            OP_INV_B:  x = ~b;
            OP_AND_B:  x = zext1(&b);
            OP_AND:    x = a & b;
            OP_OR:     x = a | b;
            OP_XOR:    x = a ^ b;
            OP_GT:     x = zext1(a > b);
            OP_LT:     x = zext1(a < b);
            OP_EQ:     x = zext1(a == b);
            OP_ADD: begin
                wide = {4'h0, a} + {4'h0, b};
                x    = wide[3:0];
                y    = wide[7:4];
            end
            OP_SUB: begin
                wide = {4'h0, a} - {4'h0, b};
                x    = wide[3:0];
                y    = wide[7:4];
            end
            default: x = 4'h0;
        endcase
    end

endmodule

// File: rtl/alu4_cmd_ctrl.sv
// Command FIFO feeding an ALU and a single response register; ALU4_ACC_EN adds an accumulator operand.
// Latency: 2 edges from command accept into an empty block to response consumable.
// Backpressure: cmd_ready = !fifo_full; response register holds stable while rsp_ready is low.
module alu4_cmd_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
`ifdef ALU4_ACC_EN
    input  logic       cmd_acc,
`endif
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_x,
    output logic [3:0] rsp_y,
    output logic [3:0] rsp_op,
    output logic       busy
);
    import alu4_pkg::*;

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [3:0]    op_mem_q [FIFO_DEPTH];
    logic [3:0]    a_mem_q  [FIFO_DEPTH];
    logic [3:0]    b_mem_q  [FIFO_DEPTH];
`ifdef ALU4_ACC_EN
    logic          acc_mem_q [FIFO_DEPTH];
    logic [3:0]    acc_q, acc_d;
`endif

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [3:0]    rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d, rsp_op_q, rsp_op_d;

    logic          fifo_full, fifo_empty, push, load;
    logic [3:0]    head_op, head_a, head_b, core_a, core_x, core_y;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = !fifo_full;
    assign rsp_valid  = (state_q != ST_IDLE);
    assign busy       = !fifo_empty || rsp_valid;
    assign rsp_x      = rsp_x_q;
    assign rsp_y      = rsp_y_q;
    assign rsp_op     = rsp_op_q;

    // Full check alone gates push, so a same-cycle pop never frees a slot early
    assign push = cmd_valid && !fifo_full;
    assign load = !fifo_empty && (!rsp_valid || rsp_ready);

    assign head_op = op_mem_q[rd_ptr_q];
    assign head_a  = a_mem_q[rd_ptr_q];
    assign head_b  = b_mem_q[rd_ptr_q];
`ifdef ALU4_ACC_EN
    assign core_a  = acc_mem_q[rd_ptr_q] ? acc_q : head_a;
`else
    assign core_a  = head_a;
`endif

    alu4_core u_core (
        .a  (core_a),
        .b  (head_b),
        .op (head_op),
        .x  (core_x),
        .y  (core_y)
    );

    // Pointer/count bookkeeping and response register load
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rsp_x_d  = rsp_x_q;
        rsp_y_d  = rsp_y_q;
        rsp_op_d = rsp_op_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (load) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            rsp_x_d  = core_x;
            rsp_y_d  = core_y;
            rsp_op_d = head_op;
        end
        case ({push, load})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FSM next state: a load always lands in EXEC, an unconsumed response stalls in HOLD
    always_comb begin
        state_d = ST_IDLE;
        if (load)
            state_d = ST_EXEC;
        else if (rsp_valid && !rsp_ready)
            state_d = ST_HOLD;
    end

`ifdef ALU4_ACC_EN
    // Accumulator tracks x of every executed command
    always_comb begin
        acc_d = acc_q;
        if (load) acc_d = core_x;
    end
`endif

    // Control state with asynchronous reset; discards queued and held work
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            rsp_x_q  <= 4'h0;
            rsp_y_q  <= 4'h0;
            rsp_op_q <= 4'h0;
`ifdef ALU4_ACC_EN
            acc_q    <= 4'h0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            rsp_x_q  <= rsp_x_d;
            rsp_y_q  <= rsp_y_d;
            rsp_op_q <= rsp_op_d;
`ifdef ALU4_ACC_EN
            acc_q    <= acc_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem_q[wr_ptr_q] <= cmd_op;
            a_mem_q[wr_ptr_q]  <= cmd_a;
            b_mem_q[wr_ptr_q]  <= cmd_b;
`ifdef ALU4_ACC_EN
            acc_mem_q[wr_ptr_q] <= cmd_acc;
`endif
        end
    end

endmodule

// File: tb/tb_alu4_cmd_ctrl.sv
// Self-checking bench for alu4_cmd_ctrl: directed vectors plus a queue-based reference model.
// Latency: checks the 2-edge accept-to-consume path and back-to-back draining.
// Backpressure: exercises full FIFO, stalled responses and random rsp_ready.
module tb_alu4_cmd_ctrl;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_op, cmd_a, cmd_b;
`ifdef ALU4_ACC_EN
    logic       cmd_acc;
`endif
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_x, rsp_y, rsp_op;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_hs   = 0;
    bit mon_en   = 0;
    bit stim_done;

    logic [11:0] exp_q[$];     // {op, y, x} in acceptance order
    int          m_acc = 0;
    bit          prev_stall = 0;
    logic [11:0] prev_rsp;

    always #5 clk = ~clk;

    alu4_cmd_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
`ifdef ALU4_ACC_EN
        .cmd_acc   (cmd_acc),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_x     (rsp_x),
        .rsp_y     (rsp_y),
        .rsp_op    (rsp_op),
        .busy      (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: returns {y, x} straight from the arithmetic meaning of each opcode
    function automatic int model(input int op, input int a, input int b);
        case (op)
            0:  return (a != 0) ? 1 : 0;
            1:  return $countones(a) & 1;
            2:  return (a == 15) ? 1 : 0;
            3:  return (a == 0) ? 1 : 0;
            4:  return 15 - a;
            5:  return (b == 0) ? 1 : 0;
            6:  return 15 - b;
            7:  return (b == 15) ? 1 : 0;
            8:  return a & b;
            9:  return a | b;
            10: return a ^ b;
            11: return (a > b) ? 1 : 0;
            12: return (a < b) ? 1 : 0;
            13: return (a == b) ? 1 : 0;
            14: return a + b;
            default: return (a - b) & 255;
        endcase
    endfunction

    // Per-cycle compare against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            int outstanding;
            outstanding = exp_q.size();
            chk("busy", busy, outstanding != 0);
            chk("cmd_ready", cmd_ready, (outstanding - int'(rsp_valid)) < DEPTH);
            if (prev_stall)
                chk("stall_stable", {rsp_op, rsp_y, rsp_x}, prev_rsp);
            if (rsp_valid) begin
                if (outstanding == 0)
                    chk("unexpected_rsp", 1, 0);
                else
                    chk("rsp_fields", {rsp_op, rsp_y, rsp_x}, exp_q[0]);
                if (rsp_ready) begin
                    if (outstanding != 0) void'(exp_q.pop_front());
                    rsp_hs++;
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_rsp   = {rsp_op, rsp_y, rsp_x};
            if (cmd_valid && cmd_ready) begin
                int a_eff, r;
                a_eff = cmd_a;
`ifdef ALU4_ACC_EN
                if (cmd_acc) a_eff = m_acc;
`endif
                r = model(cmd_op, a_eff, cmd_b);
                m_acc = r & 15;
                exp_q.push_back({cmd_op, 8'(r)});
            end
        end else begin
            prev_stall = 0;
        end
    end

    // Offer one command until accepted; returns 1 time unit after the accepting edge
    task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        bit ok = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            step(1);
            done = !busy;
        end
        chk("drain_done", done, 1);
    endtask

    initial begin
        int n0;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = 4'h0; cmd_a = 4'h0; cmd_b = 4'h0;
`ifdef ALU4_ACC_EN
        cmd_acc = 1'b0;
`endif
        #22;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_xyop", {rsp_op, rsp_y, rsp_x}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        step(1);
        chk("rst_cmd_ready", cmd_ready, 1);

        // Add with carry: 9+8 = 0x11, visible one edge after accept
        rsp_ready = 1'b1;
        send(4'd14, 4'd9, 4'd8);
        chk("lat_not_yet", rsp_valid, 0);
        step(1);
        chk("lat_valid", rsp_valid, 1);
        chk("add_x", rsp_x, 4'h1);
        chk("add_y", rsp_y, 4'h1);
        chk("add_op", rsp_op, 4'd14);
        step(1);
        chk("lat_consumed", rsp_valid, 0);

        // Borrowing subtract and equality
        send(4'd15, 4'd3, 4'd5);
        step(1);
        chk("sub_x", rsp_x, 4'hE);
        chk("sub_y", rsp_y, 4'hF);
        step(1);
        send(4'd13, 4'd7, 4'd7);
        step(1);
        chk("eq_x", rsp_x, 4'h1);
        chk("eq_y", rsp_y, 4'h0);
        step(2);

        // Stall: one held plus a full FIFO, then drain back-to-back
        rsp_ready = 1'b0;
        send(4'd0, 4'd3, 4'd5);
        send(4'd4, 4'd12, 4'd1);
        send(4'd8, 4'd6, 4'd3);
        send(4'd11, 4'd2, 4'd9);
        send(4'd14, 4'd15, 4'd15);
        chk("full_cmd_ready", cmd_ready, 0);
        chk("full_busy", busy, 1);
        chk("held_x", rsp_x, 4'h1);
        n0 = rsp_hs;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b2b_valid", rsp_valid, 1);
        end
        step(1);
        chk("b2b_count", rsp_hs - n0, 5);
        chk("b2b_empty", rsp_valid, 0);

        // Random backpressure over 200 commands
        n0 = rsp_hs;
        stim_done = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) step(1);
                    send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)));
                end
                stim_done = 1;
            end
            begin
                while (!stim_done) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    step(1);
                end
            end
        join
        drain();
        chk("rand_count", rsp_hs - n0, 200);
        chk("rand_model_empty", exp_q.size(), 0);

        // Reset with work queued and a response held
        rsp_ready = 1'b0;
        send(4'd9, 4'd1, 4'd2);
        send(4'd10, 4'd3, 4'd4);
        send(4'd1, 4'd7, 4'd0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_acc = 0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("post_rst_valid", rsp_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", cmd_ready, 1);

`ifdef ALU4_ACC_EN
        // Accumulator substitution: 2+3=5, then acc(5)+4=9
        rsp_ready = 1'b1;
        send(4'd14, 4'd2, 4'd3);
        step(1);
        chk("acc_first_x", rsp_x, 4'h5);
        cmd_acc = 1'b1;
        send(4'd14, 4'd0, 4'd4);
        cmd_acc = 1'b0;
        step(1);
        chk("acc_second_x", rsp_x, 4'h9);
        drain();
`endif

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
